// File: rtl/sfu_seq_pkg.sv
// Shared types and constants for the SFU job sequencer.
// Holds the FSM state enum, CSR field layout, softmax select bit and command record.
package sfu_seq_pkg;

   localparam int FUNC_W      = 6;
   localparam int LEN_W       = 6;
   localparam int ROW_W       = 16;
   localparam int FUNC_LSB    = 26;
   localparam int LEN_LSB     = 20;
   localparam int SOFTMAX_BIT = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_FEED,
      S_DRAIN,
      S_STREAM,
      S_DONE
   } state_e;

   typedef struct packed {
      logic [FUNC_W-1:0] func;
      logic [LEN_W-1:0]  len;
      logic [ROW_W-1:0]  rows;
   } cmd_t;

   // SFU CSR word: {func, len, 20'b0}
   function automatic logic [31:0] csr_word(input cmd_t c);
      return (32'(c.func) << FUNC_LSB) | (32'(c.len) << LEN_LSB);
   endfunction

endpackage

// File: rtl/sfu_seq_cmd_fifo.sv
// Synchronous command FIFO for the SFU job sequencer.
// Push is honoured when not full or when a pop happens in the same cycle.
module sfu_seq_cmd_fifo
   import sfu_seq_pkg::*;
#(
   parameter int Depth = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  cmd_t wdata_i,
   input  logic pop_i,
   output cmd_t rdata_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

   cmd_t          r_mem [Depth];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign full_o  = (r_cnt == (AW+1)'(Depth));
   assign empty_o = (r_cnt == '0);
   assign w_pop   = pop_i & ~empty_o;
   assign w_push  = push_i & (~full_o | w_pop);
   assign rdata_o = r_mem[r_rptr];

   // Storage array; contents need no reset since the count guards reads.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= wdata_i;
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= (r_wptr == AW'(Depth-1)) ? '0 : r_wptr + AW'(1);
         if (w_pop)  r_rptr <= (r_rptr == AW'(Depth-1)) ? '0 : r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/sfu_job_sequencer.sv
// SFU job sequencer: queues job descriptors, programs the SFU CSR, pulses start per
// softmax row, gates input beats and counts result beats, signalling done per job.
// Optional perf counters are built when SFU_SEQ_PERF_CNT_EN is defined.
module sfu_job_sequencer
   import sfu_seq_pkg::*;
#(
   parameter int DataWidth = 512,
   parameter int LenW      = LEN_W,
   parameter int MaxLen    = 32,
   parameter int RowW      = ROW_W,
   parameter int CmdDepth  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [5:0]           cmd_func_i,
   input  logic [LenW-1:0]      cmd_len_i,
   input  logic [RowW-1:0]      cmd_rows_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DataWidth-1:0] in_bits_i,
   output logic                 sfu_in_valid_o,
   input  logic                 sfu_in_ready_i,
   output logic [DataWidth-1:0] sfu_in_bits_o,
   input  logic                 sfu_out_valid_i,
   output logic                 sfu_out_ready_o,
   input  logic [DataWidth-1:0] sfu_out_bits_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DataWidth-1:0] out_bits_o,
   output logic [31:0]          sfu_csr_o,
   output logic                 sfu_start_o,
   input  logic                 sfu_busy_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [31:0]          perf_busy_o,
   output logic [31:0]          perf_stall_o
);

   localparam int CntW = LenW + RowW;

   state_e          r_state;
   cmd_t            r_job;
   logic [31:0]     r_csr;
   logic            r_start;
   logic            r_done;
   logic            r_busy;
   logic            r_err;
   logic [RowW-1:0] r_rows_left;
   logic [CntW-1:0] r_total;
   logic [CntW-1:0] r_in_cnt;
   logic [CntW-1:0] r_out_cnt;

   cmd_t            w_cmd_in;
   cmd_t            w_fifo_rdata;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic [CntW-1:0] w_len_ext;
   logic [CntW-1:0] w_limit;
   logic            w_len_bad;
   logic            w_feed;
   logic            w_fwd;
   logic            w_in_open;
   logic            w_in_hs;
   logic            w_out_hs;

   assign w_cmd_in = {cmd_func_i, cmd_len_i, cmd_rows_i};
   assign w_pop    = (r_state == S_IDLE) & ~w_empty;

   sfu_seq_cmd_fifo #(.Depth(CmdDepth)) u_cmd_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (cmd_valid_i),
      .wdata_i (w_cmd_in),
      .pop_i   (w_pop),
      .rdata_o (w_fifo_rdata),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   // A full FIFO still takes a command in the cycle the FSM pops one.
   assign cmd_ready_o = ~w_full | w_pop;

   assign w_len_ext = CntW'(r_job.len);
   assign w_len_bad = (r_job.len == '0) | (w_len_ext > CntW'(MaxLen));
   // Per-row limit for softmax, whole-job limit for elementwise streaming.
   assign w_limit   = (r_state == S_STREAM) ? r_total : w_len_ext;

   assign w_feed    = (r_state == S_FEED) | (r_state == S_STREAM);
   assign w_fwd     = w_feed | (r_state == S_DRAIN);
   assign w_in_open = w_feed & (r_in_cnt < w_limit);

   assign sfu_in_valid_o  = in_valid_i & w_in_open;
   assign in_ready_o      = sfu_in_ready_i & w_in_open;
   assign sfu_in_bits_o   = in_bits_i;
   assign w_in_hs         = in_valid_i & sfu_in_ready_i & w_in_open;

   assign out_valid_o     = sfu_out_valid_i & w_fwd;
   assign sfu_out_ready_o = out_ready_i & w_fwd;
   assign out_bits_o      = sfu_out_bits_i;
   assign w_out_hs        = sfu_out_valid_i & out_ready_i & w_fwd;

   assign sfu_csr_o   = r_csr;
   assign sfu_start_o = r_start;
   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign err_o       = r_err;

   // Job FSM with registered start/done/busy/err outputs and beat counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_job       <= '0;
         r_csr       <= '0;
         r_start     <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_rows_left <= '0;
         r_total     <= '0;
         r_in_cnt    <= '0;
         r_out_cnt   <= '0;
      end else begin
         r_start <= 1'b0;
         r_done  <= 1'b0;
         if (w_in_hs) r_in_cnt <= r_in_cnt + CntW'(1);
         // A beat past the limit is still forwarded but flags an error.
         if (w_out_hs) begin
            if (r_out_cnt == w_limit) r_err <= 1'b1;
            else                      r_out_cnt <= r_out_cnt + CntW'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_job   <= w_fifo_rdata;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_csr       <= csr_word(r_job);
               r_rows_left <= r_job.rows;
               r_total     <= CntW'(r_job.len) * CntW'(r_job.rows);
               r_in_cnt    <= '0;
               r_out_cnt   <= '0;
               if (w_len_bad) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_job.rows == '0) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_job.func[SOFTMAX_BIT]) begin
                  r_start <= 1'b1;
                  r_state <= S_START;
               end else begin
                  r_state <= S_STREAM;
               end
            end
            S_START: begin
               r_in_cnt  <= '0;
               r_out_cnt <= '0;
               r_state   <= S_FEED;
            end
            S_FEED: begin
               if (w_in_hs && (r_in_cnt + CntW'(1) == w_limit)) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if ((r_out_cnt == w_len_ext) && !sfu_busy_i) begin
                  r_rows_left <= r_rows_left - RowW'(1);
                  if (r_rows_left == RowW'(1)) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_start <= 1'b1;
                     r_state <= S_START;
                  end
               end
            end
            S_STREAM: begin
               if ((r_out_cnt == r_total) && (r_in_cnt == r_total)) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SFU_SEQ_PERF_CNT_EN
   logic [31:0] r_perf_busy;
   logic [31:0] r_perf_stall;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   // Saturating busy and input-stall cycle counters, restarted per job.
   always_ff @(posedge clk_i) begin
      if (rst_i || (r_state == S_LOAD)) begin
         r_perf_busy  <= '0;
         r_perf_stall <= '0;
      end else begin
         if (r_busy) r_perf_busy <= sat_inc(r_perf_busy);
         if (w_feed && in_valid_i && !sfu_in_ready_i) r_perf_stall <= sat_inc(r_perf_stall);
      end
   end

   assign perf_busy_o  = r_perf_busy;
   assign perf_stall_o = r_perf_stall;
`else
   assign perf_busy_o  = '0;
   assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_sfu_job_sequencer.sv
// Testbench for sfu_job_sequencer: table of complete jobs plus directed multi-cycle
// sequences for illegal lengths, FIFO fill, mid-job reset and overflow beats.
module tb_sfu_job_sequencer;

   localparam int DW = 512;
   localparam logic [DW-1:0] KEY   = {16{32'hA5C3_5A3C}};
   localparam logic [DW-1:0] EXTRA = {16{32'hDEAD_BEEF}};

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_ready_o;
   logic [5:0]    cmd_func_i = '0;
   logic [5:0]    cmd_len_i = '0;
   logic [15:0]   cmd_rows_i = '0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [DW-1:0] in_bits_i = '0;
   logic          sfu_in_valid_o;
   logic          sfu_in_ready_i = 1'b0;
   logic [DW-1:0] sfu_in_bits_o;
   logic          sfu_out_valid_i = 1'b0;
   logic          sfu_out_ready_o;
   logic [DW-1:0] sfu_out_bits_i = '0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [DW-1:0] out_bits_o;
   logic [31:0]   sfu_csr_o;
   logic          sfu_start_o;
   logic          sfu_busy_i = 1'b0;
   logic          busy_o, done_o, err_o;
   logic [31:0]   perf_busy_o, perf_stall_o;

   always #5 clk = ~clk;

   sfu_job_sequencer dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_func_i(cmd_func_i), .cmd_len_i(cmd_len_i), .cmd_rows_i(cmd_rows_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_bits_i(in_bits_i),
      .sfu_in_valid_o(sfu_in_valid_o), .sfu_in_ready_i(sfu_in_ready_i), .sfu_in_bits_o(sfu_in_bits_o),
      .sfu_out_valid_i(sfu_out_valid_i), .sfu_out_ready_o(sfu_out_ready_o), .sfu_out_bits_i(sfu_out_bits_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_bits_o(out_bits_o),
      .sfu_csr_o(sfu_csr_o), .sfu_start_o(sfu_start_o), .sfu_busy_i(sfu_busy_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .perf_busy_o(perf_busy_o), .perf_stall_o(perf_stall_o)
   );

   typedef struct {
      logic [5:0]  func;
      logic [5:0]  len;
      logic [15:0] rows;
      bit          stall;
      logic [31:0] csr;
      int          starts;
      int          outs;
   } vec_t;

   vec_t tbl[5];

   int n_tests = 0;
   int n_fail  = 0;

   // SFU / upstream / downstream model state
   int            src_left = 0;
   int            src_seq  = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_q[$];
   bit            stall_en = 0, hold_in = 0, force_busy = 0, extra_beat = 0;
   int            n_start, n_done, n_out, n_in, out_at_done, n_extra, n_stall, n_cmd_acc;
   bit            seen_busy;
   logic [DW-1:0] last_extra;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] beat(input int k);
      return {16{32'(k) + 32'h1357_0000}};
   endfunction

   task automatic clr_mon();
      n_start = 0; n_done = 0; n_out = 0; n_in = 0; out_at_done = -1;
      n_extra = 0; n_stall = 0; seen_busy = 0;
   endtask

   // One clock: drive inputs, sample outputs mid-cycle, then update the model after the edge.
   task automatic cycle();
      logic          sin_hs, o_hs, c_hs;
      logic [DW-1:0] got_in, got_out;
      in_valid_i      = (src_left > 0) && (!stall_en || $urandom_range(0, 3) != 0);
      in_bits_i       = beat(src_seq);
      sfu_in_ready_i  = !hold_in && (!stall_en || $urandom_range(0, 3) != 0);
      sfu_out_valid_i = ((q.size() > 0) && (!stall_en || $urandom_range(0, 2) != 0)) || extra_beat;
      sfu_out_bits_i  = (q.size() > 0) ? q[0] : EXTRA;
      out_ready_i     = !stall_en || $urandom_range(0, 3) != 0;
      sfu_busy_i      = force_busy || (q.size() > 0);
      #2;
      sin_hs  = sfu_in_valid_o & sfu_in_ready_i;
      got_in  = sfu_in_bits_o;
      o_hs    = out_valid_o & out_ready_i;
      got_out = out_bits_o;
      c_hs    = cmd_valid_i & cmd_ready_o;
      if (sfu_start_o) n_start++;
      if (done_o) begin n_done++; out_at_done = n_out; end
      if (busy_o) seen_busy = 1;
      if (sfu_in_valid_o && !sfu_in_ready_i) n_stall++;
      @(posedge clk); #1;
      if (sin_hs) begin
         q.push_back(got_in ^ KEY);
         exp_q.push_back(beat(src_seq) ^ KEY);
         src_seq++; src_left--; n_in++;
      end
      if (o_hs) begin
         n_out++;
         if (exp_q.size() > 0) begin
            chk("out_bits", got_out, exp_q.pop_front());
            void'(q.pop_front());
         end else begin
            n_extra++;
            last_extra = got_out;
         end
      end
      if (c_hs) n_cmd_acc++;
   endtask

   task automatic push_cmd(input logic [5:0] f, input logic [5:0] l, input logic [15:0] r);
      int acc0;
      int k;
      acc0 = n_cmd_acc; k = 0;
      cmd_valid_i = 1; cmd_func_i = f; cmd_len_i = l; cmd_rows_i = r;
      while (n_cmd_acc == acc0 && k < 50) begin cycle(); k++; end
      cmd_valid_i = 0;
      if (n_cmd_acc == acc0) chk("cmd_push_timeout", 0, 1);
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (n_done == 0 && k < budget) begin cycle(); k++; end
      if (n_done == 0) chk("done_timeout", 0, 1);
      repeat (3) cycle();
   endtask

   task automatic do_reset();
      rst_i = 1; src_left = 0; q.delete(); exp_q.delete();
      stall_en = 0; hold_in = 0; force_busy = 0; extra_beat = 0; cmd_valid_i = 0;
      cycle(); cycle();
      rst_i = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{6'h10, 6'd4,  16'd2, 1'b0, 32'h4040_0000, 2, 8};
      tbl[1] = '{6'h01, 6'd3,  16'd5, 1'b1, 32'h0430_0000, 0, 15};
      tbl[2] = '{6'h10, 6'd1,  16'd3, 1'b1, 32'h4010_0000, 3, 3};
      tbl[3] = '{6'h01, 6'd32, 16'd1, 1'b0, 32'h0600_0000, 0, 32};
      tbl[4] = '{6'h10, 6'd2,  16'd0, 1'b0, 32'h4020_0000, 0, 0};
      n_cmd_acc = 0;
      last_extra = '0;
      clr_mon();

      // Reset state
      do_reset();
      chk("rst_ctrl", {busy_o, done_o, err_o, sfu_start_o, out_valid_o, sfu_out_ready_o}, 0);
      chk("rst_csr", sfu_csr_o, 0);
      chk("rst_cmd_ready", cmd_ready_o, 1);
      chk("rst_perf", {perf_busy_o, perf_stall_o}, 0);

      // Table of complete jobs run back to back
      for (int i = 0; i < 5; i++) begin
         clr_mon();
         stall_en = tbl[i].stall;
         src_left = int'(tbl[i].len) * int'(tbl[i].rows);
         push_cmd(tbl[i].func, tbl[i].len, tbl[i].rows);
         wait_done(3000);
         stall_en = 0;
         chk($sformatf("job%0d_csr", i), sfu_csr_o, tbl[i].csr);
         chk($sformatf("job%0d_starts", i), n_start, tbl[i].starts);
         chk($sformatf("job%0d_done", i), n_done, 1);
         chk($sformatf("job%0d_outs", i), n_out, tbl[i].outs);
         chk($sformatf("job%0d_outs_at_done", i), out_at_done, tbl[i].outs);
         chk($sformatf("job%0d_err_busy", i), {err_o, busy_o, seen_busy}, 3'b001);
      end

      // Illegal length 0 followed by a legal elementwise job
      do_reset(); clr_mon();
      push_cmd(6'h10, 6'd0, 16'd1);
      push_cmd(6'h01, 6'd2, 16'd1);
      src_left = 2;
      wait_done(500);
      chk("len0_err", err_o, 1);
      chk("len0_done", n_done, 1);
      chk("len0_next_outs", n_out, 2);
      chk("len0_starts", n_start, 0);

      // Illegal length 33 followed by a legal softmax job
      do_reset(); clr_mon();
      chk("err_cleared_by_rst", err_o, 0);
      push_cmd(6'h10, 6'd33, 16'd1);
      push_cmd(6'h10, 6'd2, 16'd1);
      src_left = 2;
      wait_done(500);
      chk("len33_err", err_o, 1);
      chk("len33_done", n_done, 1);
      chk("len33_next_outs", n_out, 2);
      chk("len33_starts", n_start, 1);

      // FIFO fill and perf stall count with the SFU input held not ready
      do_reset(); clr_mon();
      hold_in = 1; src_left = 2;
      push_cmd(6'h10, 6'd2, 16'd1);
      for (int k = 0; k < 100 && n_stall < 10; k++) cycle();
`ifdef SFU_SEQ_PERF_CNT_EN
      chk("perf_stall", perf_stall_o, 10);
`else
      chk("perf_stall_tied", {perf_busy_o, perf_stall_o}, 0);
`endif
      begin
         int acc0;
         acc0 = n_cmd_acc;
         cmd_func_i = 6'h10; cmd_len_i = 6'd2; cmd_rows_i = 16'd1;
         cmd_valid_i = 1;
         repeat (5) cycle();
         chk("fifo_accepts", n_cmd_acc - acc0, 4);
         chk("cmd_ready_full", cmd_ready_o, 0);
         hold_in = 0;
         for (int k = 0; k < 200 && n_cmd_acc == acc0 + 4; k++) cycle();
         cmd_valid_i = 0;
         chk("push_pop_full_accept", n_cmd_acc - acc0, 5);
         chk("still_full_after", cmd_ready_o, 0);
         chk("fifo_jobA_done", n_done, 1);
      end

      // Reset during FEED of the second row, with a command queued behind the job
      do_reset(); clr_mon();
      src_left = 4;
      push_cmd(6'h10, 6'd2, 16'd2);
      push_cmd(6'h01, 6'd1, 16'd1);
      for (int k = 0; k < 200 && !(n_start == 2 && n_in == 3); k++) cycle();
      chk("midrst_reached_row1", n_in, 3);
      rst_i = 1;
      cycle();
      chk("midrst_outs_zero", {busy_o, done_o, err_o, sfu_start_o, sfu_in_valid_o, in_ready_o,
                               out_valid_o, sfu_out_ready_o}, 0);
      chk("midrst_csr", sfu_csr_o, 0);
      chk("midrst_no_done", n_done, 0);
      rst_i = 0; src_left = 0; q.delete(); exp_q.delete();
      clr_mon();
      repeat (6) cycle();
      chk("midrst_fifo_flushed", {seen_busy, n_done[0]}, 0);
      chk("midrst_cmd_ready", cmd_ready_o, 1);

      // Extra output beat while draining a softmax row
      do_reset(); clr_mon();
      force_busy = 1; src_left = 2;
      push_cmd(6'h10, 6'd2, 16'd1);
      for (int k = 0; k < 200 && n_out < 2; k++) cycle();
      chk("drain_err_before", err_o, 0);
      extra_beat = 1;
      cycle();
      extra_beat = 0;
      chk("extra_forwarded", n_extra, 1);
      chk("extra_bits", last_extra, EXTRA);
      chk("extra_err", err_o, 1);
      chk("drain_held_by_busy", n_done, 0);
      force_busy = 0;
      wait_done(200);
      chk("extra_job_done", n_done, 1);
      chk("extra_err_sticky", err_o, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
